// File: rtl/disp_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | disp_pkg : shared segment patterns and scan defaults for disp_scan     |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
package disp_pkg;

  localparam int SCAN_DIV_DEFAULT     = 50000;
  localparam int FLASH_FRAMES_DEFAULT = 200;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seg7_decode : 4-bit value to active-low 7-segment pattern, dash >= 10  |
// | Revision    : 1.0                                                      |
// +-----------------------------------------------------------------------+
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/disp_scan.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | disp_scan : two-digit multiplexed 7-seg driver with carry dp flash     |
// | Revision  : 1.0                                                        |
// +-----------------------------------------------------------------------+
module disp_scan
  import disp_pkg::*;
#(
  parameter int SCAN_DIV     = SCAN_DIV_DEFAULT,
  parameter int FLASH_FRAMES = FLASH_FRAMES_DEFAULT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] nums_0,
  input  logic [2:0] nums_1,
  input  logic       cout,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp
);

  localparam int            FW         = (FLASH_FRAMES < 1) ? 1 : $clog2(FLASH_FRAMES + 1);
  localparam logic [15:0]   PRE_MAX    = 16'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_FRAMES);

  logic [15:0]   presc_q, presc_d;
  logic          idx_q, idx_d;
  logic [3:0]    snap0_q, snap0_d;
  logic [2:0]    snap1_q, snap1_d;
  logic          cout_q;
  logic [FW-1:0] flash_q, flash_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          frame_start;
  logic          cout_rise;
  logic          tens_blank;
  logic [3:0]    dec_in;
  logic [6:0]    dec_out;

  seg7_decode u_dec (
    .digit_i (dec_in),
    .seg_o   (dec_out)
  );

  always_comb begin
    tick        = (presc_q == PRE_MAX);
    frame_start = tick & idx_q;
    presc_d     = tick ? 16'd0 : presc_q + 16'd1;
    idx_d       = idx_q ^ tick;
    // Snapshots only move at frame start so both digits always come from one sample
    snap0_d     = frame_start ? nums_0 : snap0_q;
    snap1_d     = frame_start ? nums_1 : snap1_q;

    cout_rise = cout & ~cout_q;
    flash_d   = flash_q;
    if (cout_rise) begin
      flash_d = FLASH_LOAD;
    end else if (frame_start && (flash_q != '0)) begin
      flash_d = flash_q - FW'(1);
    end

    dec_in     = idx_q ? {1'b0, snap1_q} : snap0_q;
    tens_blank = idx_q & blank_lz & (snap1_q == 3'd0);
    // First cycle of every slot is dark so the segment change never ghosts
    if ((presc_q == 16'd0) || tens_blank) begin
      an_d = 2'b11;
    end else begin
      an_d = idx_q ? 2'b01 : 2'b10;
    end
    seg_d = dec_out;
    dp_d  = ~(~idx_q & (flash_q != '0));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q <= 16'd0;
      idx_q   <= 1'b0;
      snap0_q <= 4'd0;
      snap1_q <= 3'd0;
      cout_q  <= 1'b0;
      flash_q <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= 2'b11;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap0_q <= snap0_d;
      snap1_q <= snap1_d;
      cout_q  <= cout;
      flash_q <= flash_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_disp_scan : scoreboard bench for disp_scan (SCAN_DIV=4, FLASH=3)    |
// | Revision     : 1.0                                                     |
// +-----------------------------------------------------------------------+
module tb_disp_scan;

  logic       clk;
  logic       rstn;
  logic [3:0] nums_0;
  logic [2:0] nums_1;
  logic       cout;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;

  disp_scan #(
    .SCAN_DIV     (4),
    .FLASH_FRAMES (3)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .nums_0   (nums_0),
    .nums_1   (nums_1),
    .cout     (cout),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] an;
    logic       dp;
    logic       chk_seg;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int dp_low_cnt = 0;

  // Reference state: n = rising edges since reset release
  int         n;
  logic [3:0] m_s0;
  logic [2:0] m_s1;
  logic       m_cq;
  int         m_fl;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d, t=%0t)", tag, got, exp, n, $time);
    end
  endtask

  function automatic logic [6:0] pat(input int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic model_reset();
    n    = 0;
    m_s0 = 4'd0;
    m_s1 = 3'd0;
    m_cq = 1'b0;
    m_fl = 0;
    sb.delete();
  endtask

  // Push the expectation for the coming edge, advance the model, then compare.
  task automatic cycle();
    exp_t e;
    exp_t g;
    int   pre;
    int   slot;
    bit   fs;
    pre  = n % 4;
    slot = (n / 4) % 2;
    if (pre == 0)                                 e.an = 2'b11;
    else if (slot == 1 && blank_lz && m_s1 == 0) e.an = 2'b11;
    else                                          e.an = (slot == 1) ? 2'b01 : 2'b10;
    e.seg     = (slot == 1) ? pat(int'(m_s1)) : pat(int'(m_s0));
    e.chk_seg = (e.an != 2'b11);
    e.dp      = !(slot == 0 && m_fl != 0);
    sb.push_back(e);

    fs = (pre == 3) && (slot == 1);
    if (fs) begin
      m_s0 = nums_0;
      m_s1 = nums_1;
    end
    if (cout && !m_cq)       m_fl = 3;
    else if (fs && m_fl > 0) m_fl = m_fl - 1;
    m_cq = cout;
    n++;

    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 16'd1, 16'd0);
    end else begin
      g = sb.pop_front();
      check_eq("an", {14'd0, an}, {14'd0, g.an});
      check_eq("dp", {15'd0, dp}, {15'd0, g.dp});
      if (g.chk_seg) check_eq("seg", {9'd0, seg}, {9'd0, g.seg});
    end
    if (dp == 1'b0) dp_low_cnt++;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic align_fs();
    while ((n % 8) != 7) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_seg"}, {9'd0, seg}, 16'h7F);
    check_eq({tag, "_an"},  {14'd0, an}, 16'h3);
    check_eq({tag, "_dp"},  {15'd0, dp}, 16'h1);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    rstn     = 1'b0;
    nums_0   = 4'd5;
    nums_1   = 3'd3;
    cout     = 1'b0;
    blank_lz = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_reset();

    // Snapshot is 0 until the first frame start, then 5/3
    run(24);

    // Mid-frame change must not tear
    while ((n % 8) != 3) cycle();
    nums_0 = 4'd1;
    run(16);

    // Out-of-range units digits show dash
    nums_0 = 4'd10;
    run(16);
    nums_0 = 4'd15;
    nums_1 = 3'd7;
    run(16);
    nums_0 = 4'd9;

    // Leading-zero blanking on and off
    nums_1   = 3'd0;
    blank_lz = 1'b1;
    run(24);
    blank_lz = 1'b0;
    run(16);

    // Single pulse coinciding with frame start: three full units slots of dp
    run(8);
    align_fs();
    dp_low_cnt = 0;
    cout = 1'b1;
    cycle();
    cout = 1'b0;
    run(48);
    check_eq("dp_pulse_cycles", 16'(dp_low_cnt), 16'd12);

    // Held-high carry does not retrigger
    align_fs();
    dp_low_cnt = 0;
    cout = 1'b1;
    run(80);
    check_eq("dp_held_cycles", 16'(dp_low_cnt), 16'd12);
    cout = 1'b0;
    run(8);

    // New edge while flashing reloads
    cout = 1'b1;
    cycle();
    cout = 1'b0;
    run(13);
    cout = 1'b1;
    cycle();
    cout = 1'b0;
    run(40);

    // Asynchronous reset in a tens slot with flash active
    nums_0 = 4'd5;
    nums_1 = 3'd3;
    cout   = 1'b1;
    cycle();
    cout   = 1'b0;
    while ((n % 8) != 5) cycle();
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    release_reset();
    run(32);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per digit slot; legal range 2..65535.
REQ-002 Parameter FLASH_FRAMES, default 200, scan frames the dp indicator stays lit after a carry.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 nums_0  input  4  units digit from the upstream seconds counter, binary 0..15.
REQ-006 nums_1  input  3  tens digit from the upstream seconds counter, binary 0..7.
REQ-007 cout  input  1  carry/wrap flag from the upstream seconds counter, level.
REQ-008 blank_lz  input  1  1 = blank tens digit when its value is 0.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 an  output  2  digit enables, an[0] = units, an[1] = tens, active-low.
REQ-011 dp  output  1  decimal point on units digit, active-low.

Function
REQ-012 The prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; tick = (prescaler == SCAN_DIV-1).
REQ-013 The 1-bit digit index SHALL toggle on every tick; 0 = units slot, 1 = tens slot.
REQ-014 Frame start = tick while digit index == 1; on frame start nums_0, nums_1 SHALL be latched into snapshot registers; displayed values change only at frame start (no tearing).
REQ-015 Decode SHALL map 0..9 to standard patterns (0 = 7'h40, 1 = 7'h79, 3 = 7'h30, 5 = 7'h12); any value 10..15 SHALL display dash 7'h3F.
REQ-016 Tens snapshot SHALL be zero-extended to 4 bits before decode.
REQ-017 an SHALL be 2'b11 for every cycle in which prescaler == 0 (one-cycle anti-ghost blanking), otherwise the bit of the current digit index low and the other high.
REQ-018 In a tens slot with blank_lz = 1 and tens snapshot == 0, an SHALL stay 2'b11 for the entire slot.
REQ-019 seg, an, dp SHALL be registered: outputs in cycle t+1 reflect prescaler/index/snapshot state in cycle t.
REQ-020 cout SHALL be sampled into cout_q each cycle; rising edge (cout & ~cout_q) SHALL load flash counter with FLASH_FRAMES.
REQ-021 Flash counter SHALL decrement by 1 on each frame start while nonzero and saturate at 0.
REQ-022 dp SHALL be 0 only during units slots while flash counter != 0, otherwise 1.
REQ-023 Rising edge of cout coinciding with frame start: reload wins over decrement.
REQ-024 A cout held high SHALL not retrigger; a new rising edge while the flash counter is nonzero SHALL reload it to FLASH_FRAMES.

Reset
REQ-025 rstn low SHALL asynchronously clear prescaler, digit index, snapshots, cout_q, flash counter to 0.
REQ-026 Reset values: seg = 7'h7F, an = 2'b11, dp = 1.
REQ-027 Reset mid-slot SHALL restart at units slot, prescaler 0, no flash, and snapshot 0 until the first frame start after release.

Structure
REQ-028 Segment pattern constants (digits 0..9, dash, all-off 7'h7F) and the SCAN_DIV/FLASH_FRAMES defaults SHALL live in shared package disp_pkg.
REQ-029 One combinational sub-module seg7_decode (4-bit in, 7-bit active-low out) SHALL be instantiated once, fed by a mux of the two snapshots.

Verification (SCAN_DIV = 4, FLASH_FRAMES = 3)
REQ-030 Reset release, nums_0 = 5, nums_1 = 3 -> after first frame start, units slots show seg = 7'h12/an = 2'b10, tens slots show 7'h30/an = 2'b01; an = 2'b11 one cycle per slot.
REQ-031 nums_0 changes 5 -> 1 mid-frame -> seg stays 7'h12 until the next frame start, then 7'h79.
REQ-032 nums_0 = 10 held across a frame start -> units slot shows dash 7'h3F.
REQ-033 blank_lz = 1, nums_1 = 0 -> an = 2'b11 for the full tens slot; blank_lz = 0 -> tens shows 7'h40.
REQ-034 Single-cycle cout pulse -> dp = 0 in units slots for exactly 3 frames, then 1; cout held high 10 frames -> still exactly 3 frames.
REQ-035 rstn asserted mid tens slot with flash active -> outputs 7'h7F/2'b11/1 immediately; after release the first active slot is units.
